// File: rtl/client_pkg.sv
// ============================================================================
// Module      : client_pkg
// Description : Shared press codes, display glyphs and menu state encoding
//               for the client menu level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package client_pkg;

    localparam logic [2:0] c_PRESS_NXT  = 3'b000;
    localparam logic [2:0] c_PRESS_RLS  = 3'b001;
    localparam logic [2:0] c_PRESS_CON  = 3'b010;
    localparam logic [2:0] c_PRESS_DEL  = 3'b011;
    localparam logic [2:0] c_PRESS_RIS  = 3'b100;
    localparam logic [2:0] c_PRESS_NONE = 3'b111;

    localparam logic [4:0] c_GLYPH_C     = 5'd12;
    localparam logic [4:0] c_GLYPH_E     = 5'd14;
    localparam logic [4:0] c_GLYPH_I     = 5'd17;
    localparam logic [4:0] c_GLYPH_L     = 5'd19;
    localparam logic [4:0] c_GLYPH_N     = 5'd20;
    localparam logic [4:0] c_GLYPH_O     = 5'd21;
    localparam logic [4:0] c_GLYPH_R     = 5'd24;
    localparam logic [4:0] c_GLYPH_T     = 5'd25;
    localparam logic [4:0] c_GLYPH_BLANK = 5'd31;

    localparam logic [29:0] c_SHOW_IDLE =
        {c_GLYPH_C, c_GLYPH_L, c_GLYPH_I, c_GLYPH_E, c_GLYPH_N, c_GLYPH_T};
    localparam logic [29:0] c_SHOW_ERR =
        {c_GLYPH_E, c_GLYPH_R, c_GLYPH_R, c_GLYPH_O, c_GLYPH_R, c_GLYPH_BLANK};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ERR    = 2'd1,
        S_ACTIVE = 2'd2,
        S_EXIT   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/onehot_select.sv
// ============================================================================
// Module      : onehot_select
// Description : Checks that exactly one switch bit is set and that its index
//               addresses an existing channel; encodes that index.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_select #(
    parameter int N_CH = 3,
    parameter int SW_W = 8
) (
    input  logic [SW_W-1:0] switch,
    output logic            valid,
    output logic [2:0]      idx
);

    int   w_pos;
    logic w_single;

    always_comb begin
        w_pos = 0;
        for (int i = 0; i < SW_W; i++) begin
            if (switch[i]) w_pos = i;
        end
    end

    // x & (x-1) clears the lowest set bit, so zero means at most one bit was set
    assign w_single = (switch != '0) && ((switch & (switch - SW_W'(1))) == '0);
    assign valid    = w_single && (w_pos < N_CH);
    assign idx      = 3'(w_pos);

endmodule

`default_nettype wire

// File: rtl/client_menu_dispatcher.sv
// ============================================================================
// Module      : client_menu_dispatcher
// Description : Client menu: selects one of N_CH child blocks from the
//               switches, muxes its show bus and returns on done/back.
//               Optional inactivity exit: CLIENT_MENU_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module client_menu_dispatcher
    import client_pkg::*;
#(
    parameter int                N_CH        = 3,
    parameter int                SW_W        = 8,
    parameter int                SHOW_W      = 30,
    parameter logic [SHOW_W-1:0] IDLE_SHOW   = SHOW_W'(c_SHOW_IDLE),
    parameter int                ERR_CYC     = 100_000_000,
    parameter int                TIMEOUT_CYC = 1_000_000_000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [2:0]               press,
    input  logic [SW_W-1:0]          switch,
    input  logic [N_CH*SHOW_W-1:0]   ch_show_i,
    input  logic [N_CH-1:0]          ch_done_i,
    output logic [N_CH-1:0]          ch_en_o,
    output logic [2:0]               sel_o,
    output logic [SHOW_W-1:0]        show_o,
    output logic [N_CH-1:0]          led_sel_o,
    output logic                     father_rst_o
);

    localparam int                 c_ERR_W    = $clog2(ERR_CYC) + 1;
    localparam logic [c_ERR_W-1:0] c_ERR_LOAD = c_ERR_W'(ERR_CYC - 1);
    localparam logic [SHOW_W-1:0]  c_BLANK    = '1;
    localparam logic [SHOW_W-1:0]  c_ERR_SHOW = SHOW_W'(c_SHOW_ERR);

    state_t              r_state, w_state_nxt;
    logic [c_ERR_W-1:0]  r_err_cnt, w_err_cnt_nxt;
    logic [N_CH-1:0]     r_ch_en, w_ch_en_nxt;
    logic [N_CH-1:0]     r_led, w_led_nxt;
    logic [2:0]          r_sel, w_sel_nxt;
    logic [SHOW_W-1:0]   r_show, w_show_nxt;
    logic                r_father, w_father_nxt;

    logic                w_sw_valid;
    logic [2:0]          w_sw_idx;
    logic [N_CH-1:0]     w_sw_onehot;
    logic [SHOW_W-1:0]   w_ch_show_mux;
    logic                w_done;
    logic                w_timeout;

    onehot_select #(
        .N_CH (N_CH),
        .SW_W (SW_W)
    ) u_onehot_select (
        .switch (switch),
        .valid  (w_sw_valid),
        .idx    (w_sw_idx)
    );

    // r_ch_en is one-hot of the locked selection, so it doubles as the mux select
    always_comb begin
        w_ch_show_mux = '0;
        for (int k = 0; k < N_CH; k++) begin
            w_sw_onehot[k] = (w_sw_idx == 3'(k));
            if (r_ch_en[k]) w_ch_show_mux = ch_show_i[k*SHOW_W +: SHOW_W];
        end
    end

    assign w_done = |(ch_done_i & r_ch_en);

`ifdef CLIENT_MENU_TIMEOUT_EN
    localparam int                c_TO_W    = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYC - 1);

    logic [c_TO_W-1:0] r_to_cnt;

    always_ff @(posedge clk) begin
        if (rst || !en || r_state != S_ACTIVE) begin
            r_to_cnt <= '0;
        end else if (press != c_PRESS_NONE) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != c_TO_LAST) begin
            r_to_cnt <= r_to_cnt + c_TO_W'(1);
        end
    end

    assign w_timeout = (r_state == S_ACTIVE) && (r_to_cnt == c_TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_err_cnt_nxt = r_err_cnt;
        w_ch_en_nxt   = '0;
        w_led_nxt     = '0;
        w_sel_nxt     = '0;
        w_show_nxt    = c_BLANK;
        w_father_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (press == c_PRESS_CON) begin
                    if (w_sw_valid) begin
                        w_state_nxt = S_ACTIVE;
                    end else begin
                        w_state_nxt   = S_ERR;
                        w_err_cnt_nxt = c_ERR_LOAD;
                    end
                end else if (press == c_PRESS_RLS) begin
                    w_father_nxt = 1'b1;
                end
            end
            S_ERR: begin
                if (press != c_PRESS_NONE || r_err_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_err_cnt_nxt = r_err_cnt - c_ERR_W'(1);
                end
            end
            S_ACTIVE: begin
                if (w_done || press == c_PRESS_RIS || w_timeout) w_state_nxt = S_EXIT;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Registered outputs describe the state being entered
        case (w_state_nxt)
            S_IDLE: w_show_nxt = IDLE_SHOW;
            S_ERR:  w_show_nxt = c_ERR_SHOW;
            S_ACTIVE: begin
                if (r_state == S_ACTIVE) begin
                    w_ch_en_nxt = r_ch_en;
                    w_led_nxt   = r_led;
                    w_sel_nxt   = r_sel;
                    w_show_nxt  = w_ch_show_mux;
                end else begin
                    w_ch_en_nxt = w_sw_onehot;
                    w_led_nxt   = w_sw_onehot;
                    w_sel_nxt   = w_sw_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_state   <= S_IDLE;
            r_err_cnt <= '0;
            r_ch_en   <= '0;
            r_led     <= '0;
            r_sel     <= '0;
            r_show    <= c_BLANK;
            r_father  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_err_cnt <= w_err_cnt_nxt;
            r_ch_en   <= w_ch_en_nxt;
            r_led     <= w_led_nxt;
            r_sel     <= w_sel_nxt;
            r_show    <= w_show_nxt;
            r_father  <= w_father_nxt;
        end
    end

    assign ch_en_o      = r_ch_en;
    assign led_sel_o    = r_led;
    assign sel_o        = r_sel;
    assign show_o       = r_show;
    assign father_rst_o = r_father;

endmodule

`default_nettype wire

// File: tb/tb_client_menu_dispatcher.sv
// ============================================================================
// Module      : tb_client_menu_dispatcher
// Description : Directed self-checking bench for client_menu_dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_client_menu_dispatcher;

    localparam int N_CH   = 3;
    localparam int SW_W   = 8;
    localparam int SHOW_W = 30;

    localparam logic [2:0] P_NXT  = 3'b000;
    localparam logic [2:0] P_RLS  = 3'b001;
    localparam logic [2:0] P_CON  = 3'b010;
    localparam logic [2:0] P_RIS  = 3'b100;
    localparam logic [2:0] P_NONE = 3'b111;

    localparam logic [29:0] E_BLANK = 30'h3FFF_FFFF;
    localparam logic [29:0] E_IDLE  = {5'd12, 5'd19, 5'd17, 5'd14, 5'd20, 5'd25};
    localparam logic [29:0] E_ERR   = {5'd14, 5'd24, 5'd24, 5'd21, 5'd24, 5'd31};
    localparam logic [29:0] CH0_SH  = 30'h0AAA_AAAA;
    localparam logic [29:0] CH1_SH  = 30'h0123_4567;
    localparam logic [29:0] CH2_SH  = 30'h0555_5555;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   en;
    logic [2:0]             press;
    logic [SW_W-1:0]        switch;
    logic [N_CH*SHOW_W-1:0] ch_show_i;
    logic [N_CH-1:0]        ch_done_i;
    logic [N_CH-1:0]        ch_en_o;
    logic [2:0]             sel_o;
    logic [SHOW_W-1:0]      show_o;
    logic [N_CH-1:0]        led_sel_o;
    logic                   father_rst_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    client_menu_dispatcher #(
        .N_CH        (N_CH),
        .SW_W        (SW_W),
        .SHOW_W      (SHOW_W),
        .ERR_CYC     (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .press        (press),
        .switch       (switch),
        .ch_show_i    (ch_show_i),
        .ch_done_i    (ch_done_i),
        .ch_en_o      (ch_en_o),
        .sel_o        (sel_o),
        .show_o       (show_o),
        .led_sel_o    (led_sel_o),
        .father_rst_o (father_rst_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        press     = P_NONE;
        switch    = '0;
        ch_show_i = {CH2_SH, CH1_SH, CH0_SH};
        ch_done_i = '0;
        tick();
        tick();
        check("rst_show",   32'(show_o),       32'(E_BLANK));
        check("rst_ch_en",  32'(ch_en_o),      32'd0);
        check("rst_sel",    32'(sel_o),        32'd0);
        check("rst_led",    32'(led_sel_o),    32'd0);
        check("rst_father", 32'(father_rst_o), 32'd0);

        rst = 1'b0;
        en  = 1'b1;
        tick();
        check("idle_show",  32'(show_o),  32'(E_IDLE));
        check("idle_ch_en", 32'(ch_en_o), 32'd0);

        // valid selection of channel 1
        switch = 8'b0000_0010;
        press  = P_CON;
        tick();
        press = P_NONE;
        check("sel1_ch_en", 32'(ch_en_o),   32'b010);
        check("sel1_sel",   32'(sel_o),     32'd1);
        check("sel1_led",   32'(led_sel_o), 32'b010);
        check("sel1_first", 32'(show_o),    32'(E_BLANK));
        switch = 8'b0000_0001;
        tick();
        check("sel1_show",  32'(show_o),    32'(CH1_SH));
        check("sel1_lock",  32'(ch_en_o),   32'b010);
        ch_done_i = 3'b001;
        tick();
        check("sel1_other_done", 32'(ch_en_o), 32'b010);
        ch_done_i = 3'b010;
        tick();
        ch_done_i = '0;
        check("sel1_exit_en",   32'(ch_en_o), 32'd0);
        check("sel1_exit_show", 32'(show_o),  32'(E_BLANK));
        tick();
        check("sel1_back_idle", 32'(show_o),  32'(E_IDLE));

        // two bits set: error banner for ERR_CYC cycles
        switch = 8'b0000_0011;
        press  = P_CON;
        tick();
        press = P_NONE;
        check("err2_show",  32'(show_o),  32'(E_ERR));
        check("err2_ch_en", 32'(ch_en_o), 32'd0);
        tick();
        tick();
        tick();
        check("err2_hold",  32'(show_o),  32'(E_ERR));
        tick();
        check("err2_idle",  32'(show_o),  32'(E_IDLE));

        // bit beyond N_CH: error, left early by a press
        switch = 8'b0000_1000;
        press  = P_CON;
        tick();
        check("err_range_show", 32'(show_o), 32'(E_ERR));
        press = P_NXT;
        tick();
        press = P_NONE;
        check("err_press_idle", 32'(show_o), 32'(E_IDLE));

        // channel 0: foreign done ignored, done + ris give a single exit
        switch = 8'b0000_0001;
        press  = P_CON;
        tick();
        press = P_NONE;
        check("sel0_ch_en", 32'(ch_en_o), 32'b001);
        check("sel0_sel",   32'(sel_o),   32'd0);
        ch_done_i = 3'b100;
        tick();
        check("sel0_ignore", 32'(ch_en_o), 32'b001);
        check("sel0_show",   32'(show_o),  32'(CH0_SH));
        ch_done_i = 3'b001;
        press     = P_RIS;
        tick();
        check("sel0_exit_en",  32'(ch_en_o),   32'd0);
        check("sel0_exit_led", 32'(led_sel_o), 32'd0);
        tick();
        ch_done_i = '0;
        press     = P_NONE;
        check("sel0_idle_show", 32'(show_o),  32'(E_IDLE));
        check("sel0_idle_en",   32'(ch_en_o), 32'd0);

        // release request pulse
        press = P_RLS;
        tick();
        press = P_NONE;
        check("rls_high", 32'(father_rst_o), 32'd1);
        check("rls_idle", 32'(show_o),       32'(E_IDLE));
        tick();
        check("rls_low",  32'(father_rst_o), 32'd0);

        // enable dropped while active
        switch = 8'b0000_0100;
        press  = P_CON;
        tick();
        press = P_NONE;
        check("sel2_ch_en", 32'(ch_en_o), 32'b100);
        check("sel2_sel",   32'(sel_o),   32'd2);
        en = 1'b0;
        tick();
        check("en0_ch_en",  32'(ch_en_o),      32'd0);
        check("en0_sel",    32'(sel_o),        32'd0);
        check("en0_led",    32'(led_sel_o),    32'd0);
        check("en0_show",   32'(show_o),       32'(E_BLANK));
        check("en0_father", 32'(father_rst_o), 32'd0);
        en = 1'b1;
        tick();
        check("en1_idle",   32'(show_o),       32'(E_IDLE));

`ifdef CLIENT_MENU_TIMEOUT_EN
        // no press: exit after 8 active cycles
        switch = 8'b0000_0001;
        press  = P_CON;
        tick();
        press = P_NONE;
        for (int i = 1; i <= 7; i++) tick();
        check("to_still_active", 32'(ch_en_o), 32'b001);
        tick();
        check("to_exit", 32'(ch_en_o), 32'd0);
        tick();

        // a press at the fifth cycle restarts the count
        press = P_CON;
        tick();
        press = P_NONE;
        for (int i = 1; i <= 4; i++) tick();
        press = P_NXT;
        tick();
        press = P_NONE;
        for (int i = 6; i <= 12; i++) tick();
        check("to_restart_active", 32'(ch_en_o), 32'b001);
        tick();
        check("to_restart_exit", 32'(ch_en_o), 32'd0);
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
